// File: rtl/flash_sample_reader.sv
// Streams 32-bit flash words as two attenuated signed 16-bit samples (low half first).
// Define LOOP_PLAYBACK_EN to wrap playback back to address 0 instead of stopping.
module flash_sample_reader #(
  parameter logic [22:0] LAST_ADDR = 23'h0FFFFF,
  parameter int          ATTEN_DIV = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        flash_mem_read,
  input  logic        flash_mem_waitrequest,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    EMIT_LO,
    EMIT_HI,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] word;

  // Signed division truncates toward zero, unlike an arithmetic shift.
  function automatic logic [15:0] attenuate(input logic [15:0] s);
    return 16'(32'(signed'(s)) / ATTEN_DIV);
  endfunction

  assign flash_mem_byteenable = 4'b1111;

  // The half-word follows the registered state, so it is stable while sample_valid waits for sample_ready.
  assign sample_data = sample_valid ?
                       attenuate((state == EMIT_HI) ? word[31:16] : word[15:0]) : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
      word              <= '0;
      sample_valid      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state             <= REQ;
            flash_mem_address <= '0;
            flash_mem_read    <= 1'b1;
            busy              <= 1'b1;
          end
        end
        REQ: begin
          if (!flash_mem_waitrequest) begin
            state          <= WAIT_DATA;
            flash_mem_read <= 1'b0;
          end
        end
        WAIT_DATA: begin
          if (flash_mem_readdatavalid) begin
            word         <= flash_mem_readdata;
            sample_valid <= 1'b1;
            state        <= EMIT_LO;
          end
        end
        EMIT_LO: begin
          if (sample_ready) begin
            state <= EMIT_HI;
          end
        end
        EMIT_HI: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            if (flash_mem_address != LAST_ADDR) begin
              flash_mem_address <= flash_mem_address + 23'd1;
              flash_mem_read    <= 1'b1;
              state             <= REQ;
            end else begin
`ifdef LOOP_PLAYBACK_EN
              flash_mem_address <= '0;
              flash_mem_read    <= 1'b1;
              state             <= REQ;
`else
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`endif
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Self-checking bench for flash_sample_reader: scripted flash responses feed a scoreboard of expected samples.
// Honours LOOP_PLAYBACK_EN for the end-of-playback expectations.
module tb_flash_sample_reader;

  localparam logic [22:0] LAST = 23'd3;
  localparam int          DIV  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flash_mem_read;
  logic        flash_mem_waitrequest = 1'b1;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic [31:0] flash_mem_readdata = 32'h0;
  logic        flash_mem_readdatavalid = 1'b0;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        busy;
  logic        done;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          sample_count = 0;
  int          done_count = 0;
  logic [15:0] exp_q[$];

  flash_sample_reader #(.LAST_ADDR(LAST), .ATTEN_DIV(DIV)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start                   (start),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .sample_data             (sample_data),
    .sample_valid            (sample_valid),
    .sample_ready            (sample_ready),
    .busy                    (busy),
    .done                    (done)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Sign-magnitude model of round-toward-zero division.
  function automatic logic [15:0] exp_sample(input logic [15:0] s);
    logic [16:0] mag;
    logic [16:0] q;
    mag = s[15] ? (17'h10000 - {1'b0, s}) : {1'b0, s};
    q   = mag / 17'(DIV);
    return s[15] ? 16'(17'h0 - q) : q[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_read"}, flash_mem_read, 0);
    checkOutput({tag, "_addr"}, flash_mem_address, 0);
    checkOutput({tag, "_valid"}, sample_valid, 0);
    checkOutput({tag, "_data"}, sample_data, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_byteen"}, flash_mem_byteenable, 4'hF);
  endtask

  // Plays the flash side of one read: stall, accept, then optionally return a word.
  task automatic applyStimulus(input logic [22:0] addr, input int wait_cycles, input int latency,
                               input logic [31:0] data, input bit deliver);
    int guard = 0;
    while (flash_mem_read !== 1'b1 && guard < 60) begin
      tick();
      guard++;
    end
    checkOutput("read_seen", flash_mem_read, 1);
    if (flash_mem_read !== 1'b1) return;
    for (int i = 0; i < wait_cycles; i++) begin
      checkOutput("read_hold", {flash_mem_read, flash_mem_address}, {1'b1, addr});
      checkOutput("busy_req", busy, 1);
      tick();
    end
    flash_mem_waitrequest = 1'b0;
    checkOutput("read_addr", {flash_mem_read, flash_mem_address}, {1'b1, addr});
    tick();
    flash_mem_waitrequest = 1'b1;
    checkOutput("read_drop", flash_mem_read, 0);
    for (int i = 0; i < latency; i++) begin
      tick();
      checkOutput("read_idle", flash_mem_read, 0);
    end
    if (deliver) begin
      exp_q.push_back(exp_sample(data[15:0]));
      exp_q.push_back(exp_sample(data[31:16]));
      flash_mem_readdata      = data;
      flash_mem_readdatavalid = 1'b1;
      tick();
      flash_mem_readdatavalid = 1'b0;
      flash_mem_readdata      = 32'hDEAD_BEEF;
      checkOutput("valid_latency", sample_valid, 1);
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_state(tag);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic end_playback(input int exp_total);
    int guard = 0;
`ifdef LOOP_PLAYBACK_EN
    applyStimulus(23'd0, 1, 0, 32'h0C80_F380, 1'b1);
    applyStimulus(23'd1, 0, 1, 32'h0001_0001, 1'b1);
    while (exp_q.size() != 0 && guard < 40) begin
      tick();
      guard++;
    end
    checkOutput("loop_drained", exp_q.size(), 0);
    checkOutput("loop_samples", sample_count, exp_total + 4);
    checkOutput("loop_busy", busy, 1);
    checkOutput("loop_done_never", done_count, 0);
    pulse_reset("loop_stop");
`else
    while (done !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_in_done", busy, 0);
    checkOutput("samples", sample_count, exp_total);
    checkOutput("queue_drained", exp_q.size(), 0);
    tick();
    checkOutput("done_once", done, 0);
    checkOutput("busy_after", busy, 0);
`endif
  endtask

  // Scoreboard side: every cycle with sample_valid must show the oldest expected sample.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) done_count++;
      if (sample_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_sample", sample_valid, 0);
        end else begin
          checkOutput("sample_data", sample_data, exp_q[0]);
          if (sample_ready === 1'b1) begin
            void'(exp_q.pop_front());
            sample_count++;
          end
        end
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #5 check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Continuous playback with a ready sink and assorted rounding corners.
    pulse_start();
    applyStimulus(23'd0, 3, 2, 32'h1400_FFC0, 1'b1);
    applyStimulus(23'd1, 0, 0, 32'h7FFF_8000, 1'b1);
    applyStimulus(23'd2, 1, 1, 32'hFFC1_FF80, 1'b1);
    applyStimulus(23'd3, 2, 0, 32'h0040_003F, 1'b1);
    end_playback(8);

    // Back-pressure in EMIT_LO, then a start pulse during EMIT_HI.
    sample_ready = 1'b0;
    pulse_start();
    applyStimulus(23'd0, 0, 0, 32'h1234_4321, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid", sample_valid, 1);
      checkOutput("stall_no_read", flash_mem_read, 0);
      tick();
    end
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    pulse_start();
    checkOutput("hi_valid", sample_valid, 1);
    checkOutput("hi_addr", flash_mem_address, 0);
    tick();
    sample_ready = 1'b1;
    applyStimulus(23'd1, 0, 0, 32'hFFFF_0000, 1'b1);
    applyStimulus(23'd2, 0, 0, 32'h8000_7FFF, 1'b1);
    applyStimulus(23'd3, 1, 0, 32'h0C80_F380, 1'b1);
`ifdef LOOP_PLAYBACK_EN
    end_playback(20);
`else
    end_playback(16);
`endif

    // Reset while waiting for data, then a stray readdatavalid.
    pulse_start();
    applyStimulus(23'd0, 1, 0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    flash_mem_readdata      = 32'h5555_AAAA;
    flash_mem_readdatavalid = 1'b1;
    tick();
    flash_mem_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_reset_state("post_reset");
      tick();
    end
    checkOutput("queue_empty_end", exp_q.size(), 0);
`ifdef LOOP_PLAYBACK_EN
    checkOutput("done_total", done_count, 0);
`else
    checkOutput("done_total", done_count, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flash_sample_reader.md
FLASH_SAMPLE_READER -- requirements
Module: flash_sample_reader

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 23'h0FFFFF, the last flash word address played.
REQ-002 SHALL have parameter ATTEN_DIV, default 64, the signed divisor applied to every sample.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins playback from address 0.
REQ-006 SHALL have port flash_mem_read, output, 1 bit: the Avalon read request.
REQ-007 SHALL have port flash_mem_waitrequest, input, 1 bit: the flash is stalling the request.
REQ-008 SHALL have port flash_mem_address, output, 23 bits: the flash word address.
REQ-009 SHALL have port flash_mem_byteenable, output, 4 bits: tied to 4'b1111.
REQ-010 SHALL have port flash_mem_readdata, input, 32 bits: one word holding two samples.
REQ-011 SHALL have port flash_mem_readdatavalid, input, 1 bit: flash_mem_readdata is valid this cycle.
REQ-012 SHALL have port sample_data, output, 16 bits: the signed, attenuated sample.
REQ-013 SHALL have port sample_valid, output, 1 bit: sample_data is valid.
REQ-014 SHALL have port sample_ready, input, 1 bit: the downstream audio writer accepts the sample.
REQ-015 SHALL have port busy, output, 1 bit: playback is in progress.
REQ-016 SHALL have port done, output, 1 bit: high in state DONE.

Function
REQ-017 SHALL implement the states IDLE, REQ, WAIT_DATA, EMIT_LO, EMIT_HI and DONE.
REQ-018 SHALL move IDLE->REQ and load address 0 when start=1; start SHALL be ignored in every other state.
REQ-019 SHALL, in REQ, hold flash_mem_read=1 and keep the address stable while waitrequest=1.
REQ-020 SHALL move REQ->WAIT_DATA on the cycle with waitrequest=0, with flash_mem_read dropping on the next cycle.
REQ-021 SHALL, in WAIT_DATA, capture readdata into a 32-bit word register on readdatavalid=1 and move to EMIT_LO.
REQ-022 SHALL ignore readdatavalid in all states other than WAIT_DATA.
REQ-023 SHALL, in EMIT_LO, drive sample_valid=1 and sample_data = signed(word[15:0]) / ATTEN_DIV.
REQ-024 SHALL, in EMIT_HI, drive sample_valid=1 and sample_data = signed(word[31:16]) / ATTEN_DIV.
REQ-025 SHALL round the division toward zero (for example -1/64 = 0, -64/64 = -1); a bare arithmetic shift is not acceptable.
REQ-026 SHALL complete a transfer when sample_valid and sample_ready are both 1 on the same edge.
REQ-027 SHALL hold sample_data and sample_valid stable until the transfer completes.
REQ-028 SHALL move EMIT_LO->EMIT_HI on a completed transfer.
REQ-029 SHALL, on a completed transfer in EMIT_HI: if address != LAST_ADDR, increment the address and go to REQ; otherwise go to DONE.
REQ-030 SHALL go DONE->IDLE on the next cycle, and done SHALL be high for exactly 1 cycle.
REQ-031 SHALL drive busy=1 in the states REQ through EMIT_HI.
REQ-032 SHALL have a latency of 1 cycle from the captured readdatavalid to sample_valid=1.
REQ-033 SHALL accept sample_ready=1 while sample_valid=0 and SHALL ignore it in that case.

Reset
REQ-034 SHALL, while rst_n=0 (including mid-transaction), force asynchronously: state IDLE, flash_mem_read=0, flash_mem_address=0, sample_valid=0, sample_data=0, busy=0, done=0, word register=0.
REQ-035 SHALL keep flash_mem_byteenable at 4'b1111 during reset as well.
REQ-036 SHALL discard any readdatavalid that arrives after reset deasserts in IDLE.

Configuration
REQ-037 SHALL provide the macro LOOP_PLAYBACK_EN.
REQ-038 SHALL, when LOOP_PLAYBACK_EN is defined, wrap EMIT_HI at LAST_ADDR to address 0 and go to REQ; DONE is then unreachable and done stays 0.
REQ-039 SHALL, when LOOP_PLAYBACK_EN is undefined, behave as REQ-029 and REQ-030.

Verification
REQ-040 SHALL cover: start; waitrequest=1 for 3 cycles; readdatavalid 2 cycles later with data 32'h1400_FFC0 -> flash_mem_read high for 4 cycles, address 0, then samples 16'hFFFF (-64/64 = -1) followed by 16'h0050 (5120/64 = 80).
REQ-041 SHALL cover: sample_ready=0 for 10 cycles while in EMIT_LO -> sample_valid and sample_data stable throughout, no new flash read issued.
REQ-042 SHALL cover: LAST_ADDR=3, sample_ready tied to 1 -> reads at addresses 0,1,2,3, 8 samples, a single done pulse, and busy low afterwards.
REQ-043 SHALL cover: LAST_ADDR=1 with LOOP_PLAYBACK_EN defined -> address sequence 0,1,0,1,… and done never asserted.
REQ-044 SHALL cover: rst_n pulsed low while in WAIT_DATA, then readdatavalid after release -> all outputs 0, state IDLE, and no sample emitted.
REQ-045 SHALL cover: start pulsed while in EMIT_HI -> ignored, and the address sequence is unchanged.
